// File: rtl/axi_eth_pkg.sv
// Shared definitions for the Ethernet RX path: write FSM encoding, status-word layout and
// keep-vector popcount.
package axi_eth_pkg;

    typedef enum logic [3:0] {
        StSync  = 4'b0001,
        StIdle  = 4'b0010,
        StWrite = 4'b0100,
        StDrop  = 4'b1000
    } wr_state_e;

    localparam int unsigned StsWidth  = 32;
    localparam int unsigned StsSeqLsb = 24;
    localparam int unsigned StsSeqW   = 8;
    localparam int unsigned StsLenLsb = 0;
    localparam int unsigned StsLenW   = 16;
    localparam int unsigned KeepMaxW  = 16;

    typedef logic [StsLenW-1:0] len_t;
    typedef logic [StsSeqW-1:0] seq_t;

    function automatic logic [4:0] keep_popcount(input logic [KeepMaxW-1:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < KeepMaxW; i++) begin
            cnt = cnt + {4'b0000, keep[i]};
        end
        return cnt;
    endfunction

    function automatic logic [StsWidth-1:0] sts_word(input seq_t seq, input len_t len);
        return {seq, 8'h00, len};
    endfunction

endpackage

// File: rtl/axi_eth_rx_pktbuf_ram.sv
// Simple dual-port RAM with one write port and a registered read port.
module axi_eth_rx_pktbuf_ram #(
    parameter int unsigned C_WIDTH = 73,
    parameter int unsigned C_DEPTH = 512
) (
    input  logic                       clk_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(C_DEPTH)-1:0] wr_addr_i,
    input  logic [C_WIDTH-1:0]         wr_data_i,
    input  logic                       rd_en_i,
    input  logic [$clog2(C_DEPTH)-1:0] rd_addr_i,
    output logic [C_WIDTH-1:0]         rd_data_o
);

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_eth_rx_pktbuf.sv
// Store-and-forward RX packet buffer: frames are committed only when complete and good,
// dropped frames rewind the write pointer, and each committed frame yields one status beat.
module axi_eth_rx_pktbuf
    import axi_eth_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_DEPTH      = 512,
    parameter int unsigned C_STS_DEPTH  = 16,
    parameter int unsigned C_MAX_FRAME  = 9600
) (
    input  logic                      rx_clk,
    input  logic                      rx_reset,
    input  logic [C_DATA_WIDTH-1:0]   rx_axis_mac_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] rx_axis_mac_tkeep,
    input  logic                      rx_axis_mac_tlast,
    input  logic                      rx_axis_mac_tuser,
    input  logic                      rx_axis_mac_tvalid,
    output logic                      rx_axis_mac_tready,
    output logic [C_DATA_WIDTH-1:0]   rxd_tdata,
    output logic [C_DATA_WIDTH/8-1:0] rxd_tkeep,
    output logic                      rxd_tlast,
    output logic                      rxd_tvalid,
    input  logic                      rxd_tready,
    output logic [31:0]               rxs_tdata,
    output logic [3:0]                rxs_tkeep,
    output logic                      rxs_tlast,
    output logic                      rxs_tvalid,
    input  logic                      rxs_tready,
    output logic [31:0]               drop_bad_cnt,
    output logic [31:0]               drop_ovf_cnt,
    output logic [3:0]                pktbuf_fsm_dbg
);

    localparam int unsigned KeepW   = C_DATA_WIDTH / 8;
    localparam int unsigned AddrW   = $clog2(C_DEPTH);
    localparam int unsigned PtrW    = AddrW + 1;
    localparam int unsigned BeatW   = C_DATA_WIDTH + KeepW + 1;
    localparam int unsigned StsAw   = $clog2(C_STS_DEPTH);
    localparam int unsigned StsPtrW = StsAw + 1;
    localparam len_t        MaxLen  = len_t'(C_MAX_FRAME);

    wr_state_e         state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   wr_commit_q, wr_commit_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    len_t              len_q, len_d, len_base, len_new;
    logic [16:0]       len_sum;
    logic [4:0]        beat_bytes;
    seq_t              seq_q, seq_d;
    logic [31:0]       bad_cnt_q, bad_cnt_d;
    logic [31:0]       ovf_cnt_q, ovf_cnt_d;
    logic              tready_q;
    logic              beat, data_full, ram_we;

    logic [StsPtrW-1:0] sts_wr_q, sts_rd_q;
    logic [31:0]        sts_mem_q [C_STS_DEPTH];
    logic               sts_push, sts_pop, sts_full, sts_empty;

    logic             rd_issue, rd_pop;
    logic [1:0]       occ_after;
    logic             ram_vld_q;
    logic [BeatW-1:0] ram_rdata;
    logic             out_v_q, out_v_d, skid_v_q, skid_v_d;
    logic [BeatW-1:0] out_q, out_d, skid_q, skid_d;

    assign beat = rx_axis_mac_tvalid & tready_q;

    // Occupancy from registered pointers only: a read in the same cycle frees no space.
    assign data_full = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    assign sts_empty = (sts_wr_q == sts_rd_q);
    assign sts_full  = (sts_wr_q[StsAw] != sts_rd_q[StsAw]) &&
                       (sts_wr_q[StsAw-1:0] == sts_rd_q[StsAw-1:0]);
    assign sts_pop   = ~sts_empty & rxs_tready;

    assign beat_bytes = keep_popcount(KeepMaxW'(rx_axis_mac_tkeep));
    assign len_base   = (state_q == StWrite) ? len_q : '0;
    assign len_sum    = {1'b0, len_base} + {12'b0, beat_bytes};
    assign len_new    = len_sum[16] ? '1 : len_sum[15:0];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        seq_d       = seq_q;
        bad_cnt_d   = bad_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        ram_we      = 1'b0;
        sts_push    = 1'b0;
        unique case (state_q)
            StSync: begin
                // Wait for a frame boundary so a frame cut by reset is never half-committed.
                if (!rx_axis_mac_tvalid || rx_axis_mac_tlast) begin
                    state_d = StIdle;
                end
            end
            StIdle, StWrite: begin
                if (beat) begin
                    if (data_full) begin
                        wr_ptr_d  = wr_commit_q;
                        ovf_cnt_d = ovf_cnt_q + 32'd1;
                        state_d   = rx_axis_mac_tlast ? StIdle : StDrop;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                        len_d    = len_new;
                        state_d  = StWrite;
                        if (rx_axis_mac_tlast) begin
                            state_d = StIdle;
                            if (rx_axis_mac_tuser || (len_new > MaxLen)) begin
                                wr_ptr_d  = wr_commit_q;
                                bad_cnt_d = bad_cnt_q + 32'd1;
                            end else if (sts_full && !sts_pop) begin
                                wr_ptr_d  = wr_commit_q;
                                ovf_cnt_d = ovf_cnt_q + 32'd1;
                            end else begin
                                wr_commit_d = wr_ptr_q + PtrW'(1);
                                sts_push    = 1'b1;
                                seq_d       = seq_q + 8'd1;
                            end
                        end else if (len_new > MaxLen) begin
                            wr_ptr_d  = wr_commit_q;
                            bad_cnt_d = bad_cnt_q + 32'd1;
                            state_d   = StDrop;
                        end
                    end
                end
            end
            StDrop: begin
                if (beat && rx_axis_mac_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            state_q     <= StSync;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            len_q       <= '0;
            seq_q       <= '0;
            bad_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
            tready_q    <= 1'b0;
            sts_wr_q    <= '0;
            sts_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            bad_cnt_q   <= bad_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            tready_q    <= 1'b1;
            sts_wr_q    <= sts_wr_q + StsPtrW'(sts_push);
            sts_rd_q    <= sts_rd_q + StsPtrW'(sts_pop);
        end
    end

    always_ff @(posedge rx_clk) begin
        if (sts_push) begin
            sts_mem_q[sts_wr_q[StsAw-1:0]] <= sts_word(seq_q, len_new);
        end
    end

    axi_eth_rx_pktbuf_ram #(
        .C_WIDTH (BeatW),
        .C_DEPTH (C_DEPTH)
    ) u_ram (
        .clk_i     (rx_clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[AddrW-1:0]),
        .wr_data_i ({rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata}),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr_q[AddrW-1:0]),
        .rd_data_o (ram_rdata)
    );

    // Output register plus skid register; a read is issued only if its data is sure to land.
    assign rd_pop    = out_v_q & rxd_tready;
    assign occ_after = 2'(out_v_q) + 2'(skid_v_q) + 2'(ram_vld_q) - 2'(rd_pop);
    assign rd_issue  = (rd_ptr_q != wr_commit_q) && (occ_after < 2'd2);
    assign rd_ptr_d  = rd_ptr_q + PtrW'(rd_issue);

    always_comb begin
        out_v_d  = out_v_q;
        out_d    = out_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (!out_v_q || rd_pop) begin
            if (skid_v_q) begin
                out_v_d  = 1'b1;
                out_d    = skid_q;
                skid_v_d = ram_vld_q;
                skid_d   = ram_rdata;
            end else begin
                out_v_d = ram_vld_q;
                out_d   = ram_rdata;
            end
        end else if (ram_vld_q) begin
            skid_v_d = 1'b1;
            skid_d   = ram_rdata;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            rd_ptr_q  <= '0;
            ram_vld_q <= 1'b0;
            out_v_q   <= 1'b0;
            skid_v_q  <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            ram_vld_q <= rd_issue;
            out_v_q   <= out_v_d;
            skid_v_q  <= skid_v_d;
        end
        out_q  <= out_d;
        skid_q <= skid_d;
    end

    assign rx_axis_mac_tready = tready_q;
    assign rxd_tvalid         = out_v_q;
    assign {rxd_tlast, rxd_tkeep, rxd_tdata} = out_q;
    assign rxs_tvalid         = ~sts_empty;
    assign rxs_tdata          = sts_mem_q[sts_rd_q[StsAw-1:0]];
    assign rxs_tkeep          = 4'hF;
    assign rxs_tlast          = 1'b1;
    assign drop_bad_cnt       = bad_cnt_q;
    assign drop_ovf_cnt       = ovf_cnt_q;
    assign pktbuf_fsm_dbg     = state_q;

endmodule

// File: tb/tb_axi_eth_rx_pktbuf.sv
// Directed bench: a small-buffer instance (A) and a jumbo-capable instance (B) share MAC input.
module tb_axi_eth_rx_pktbuf;

    logic        clk = 1'b0;
    logic        rx_reset;
    logic [63:0] mac_tdata;
    logic [7:0]  mac_tkeep;
    logic        mac_tlast, mac_tuser, mac_tvalid;
    logic        rxd_tready, rxs_tready;

    logic        a_tready, a_rxd_tlast, a_rxd_tvalid, a_rxs_tlast, a_rxs_tvalid;
    logic [63:0] a_rxd_tdata;
    logic [7:0]  a_rxd_tkeep;
    logic [31:0] a_rxs_tdata, a_bad, a_ovf;
    logic [3:0]  a_rxs_tkeep, a_dbg;
    logic        b_tready, b_rxd_tlast, b_rxd_tvalid, b_rxs_tlast, b_rxs_tvalid;
    logic [63:0] b_rxd_tdata;
    logic [7:0]  b_rxd_tkeep;
    logic [31:0] b_rxs_tdata, b_bad, b_ovf;
    logic [3:0]  b_rxs_tkeep, b_dbg;

    logic [72:0] a_dq[$], b_dq[$];
    logic [36:0] a_sq[$], b_sq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    axi_eth_rx_pktbuf #(
        .C_DATA_WIDTH (64), .C_DEPTH (16), .C_STS_DEPTH (2), .C_MAX_FRAME (9600)
    ) u_dut_a (
        .rx_clk (clk), .rx_reset (rx_reset),
        .rx_axis_mac_tdata (mac_tdata), .rx_axis_mac_tkeep (mac_tkeep),
        .rx_axis_mac_tlast (mac_tlast), .rx_axis_mac_tuser (mac_tuser),
        .rx_axis_mac_tvalid (mac_tvalid), .rx_axis_mac_tready (a_tready),
        .rxd_tdata (a_rxd_tdata), .rxd_tkeep (a_rxd_tkeep), .rxd_tlast (a_rxd_tlast),
        .rxd_tvalid (a_rxd_tvalid), .rxd_tready (rxd_tready),
        .rxs_tdata (a_rxs_tdata), .rxs_tkeep (a_rxs_tkeep), .rxs_tlast (a_rxs_tlast),
        .rxs_tvalid (a_rxs_tvalid), .rxs_tready (rxs_tready),
        .drop_bad_cnt (a_bad), .drop_ovf_cnt (a_ovf), .pktbuf_fsm_dbg (a_dbg)
    );

    axi_eth_rx_pktbuf #(
        .C_DATA_WIDTH (64), .C_DEPTH (2048), .C_STS_DEPTH (16), .C_MAX_FRAME (9600)
    ) u_dut_b (
        .rx_clk (clk), .rx_reset (rx_reset),
        .rx_axis_mac_tdata (mac_tdata), .rx_axis_mac_tkeep (mac_tkeep),
        .rx_axis_mac_tlast (mac_tlast), .rx_axis_mac_tuser (mac_tuser),
        .rx_axis_mac_tvalid (mac_tvalid), .rx_axis_mac_tready (b_tready),
        .rxd_tdata (b_rxd_tdata), .rxd_tkeep (b_rxd_tkeep), .rxd_tlast (b_rxd_tlast),
        .rxd_tvalid (b_rxd_tvalid), .rxd_tready (rxd_tready),
        .rxs_tdata (b_rxs_tdata), .rxs_tkeep (b_rxs_tkeep), .rxs_tlast (b_rxs_tlast),
        .rxs_tvalid (b_rxs_tvalid), .rxs_tready (rxs_tready),
        .drop_bad_cnt (b_bad), .drop_ovf_cnt (b_ovf), .pktbuf_fsm_dbg (b_dbg)
    );

    always @(negedge clk) begin
        if (a_rxd_tvalid && rxd_tready) a_dq.push_back({a_rxd_tlast, a_rxd_tkeep, a_rxd_tdata});
        if (b_rxd_tvalid && rxd_tready) b_dq.push_back({b_rxd_tlast, b_rxd_tkeep, b_rxd_tdata});
        if (a_rxs_tvalid && rxs_tready) a_sq.push_back({a_rxs_tkeep, a_rxs_tlast, a_rxs_tdata});
        if (b_rxs_tvalid && rxs_tready) b_sq.push_back({b_rxs_tkeep, b_rxs_tlast, b_rxs_tdata});
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [7:0] ftag, input int i);
        logic [7:0] ix;
        ix = i[7:0];
        return {ftag, ix, 16'hC0DE, ~ftag, ix, 16'hBEEF};
    endfunction

    function automatic logic [7:0] keep_of(input int rem);
        logic [7:0] k;
        k = '0;
        for (int b = 0; b < 8; b++) if (b < rem) k[b] = 1'b1;
        return k;
    endfunction

    function automatic logic [72:0] exp_beat(input logic [7:0] ftag, input int i, input int nbytes);
        int nb;
        nb = (nbytes + 7) / 8;
        return {(i == nb - 1), keep_of(nbytes - i * 8), beat_data(ftag, i)};
    endfunction

    function automatic int q_size(input bit inst_b, input bit sts);
        if (sts) return inst_b ? b_sq.size() : a_sq.size();
        return inst_b ? b_dq.size() : a_dq.size();
    endfunction

    task automatic wait_q(input bit inst_b, input bit sts, input int n);
        for (int c = 0; c < 3000; c++) begin
            if (q_size(inst_b, sts) >= n) break;
            @(negedge clk);
        end
    endtask

    // rst_beat >= 0 pulses rx_reset for two beats starting at that beat index.
    task automatic send_frame(input int nbytes, input bit bad, input logic [7:0] ftag,
                              input int rst_beat);
        int nb;
        nb = (nbytes + 7) / 8;
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            mac_tdata  = beat_data(ftag, i);
            mac_tkeep  = keep_of(nbytes - i * 8);
            mac_tlast  = (i == nb - 1);
            mac_tuser  = bad && (i == nb - 1);
            mac_tvalid = 1'b1;
            rx_reset   = (rst_beat >= 0) && (i >= rst_beat) && (i < rst_beat + 2);
            @(posedge clk); #1;
        end
        mac_tvalid = 1'b0;
        mac_tlast  = 1'b0;
        mac_tuser  = 1'b0;
        rx_reset   = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input bit inst_b, input logic [7:0] ftag,
                                input int nbytes);
        int nb, got_n;
        logic [72:0] got;
        nb = (nbytes + 7) / 8;
        wait_q(inst_b, 1'b0, nb);
        got_n = q_size(inst_b, 1'b0);
        check_eq({tag, " beat count"}, (got_n < nb) ? got_n : nb, nb);
        for (int i = 0; i < nb && i < got_n; i++) begin
            got = inst_b ? b_dq.pop_front() : a_dq.pop_front();
            check_eq($sformatf("%s beat%0d", tag, i), got, exp_beat(ftag, i, nbytes));
        end
    endtask

    task automatic expect_sts(input string tag, input bit inst_b, input logic [31:0] exp);
        logic [36:0] got;
        wait_q(inst_b, 1'b1, 1);
        got = 'x;
        if (q_size(inst_b, 1'b1) > 0) got = inst_b ? b_sq.pop_front() : a_sq.pop_front();
        check_eq(tag, got, {4'hF, 1'b1, exp});
    endtask

    task automatic expect_quiet(input string tag);
        repeat (20) @(negedge clk);
        check_eq({tag, " A extra data"}, a_dq.size(), 0);
        check_eq({tag, " B extra data"}, b_dq.size(), 0);
        check_eq({tag, " A extra sts"}, a_sq.size(), 0);
        check_eq({tag, " B extra sts"}, b_sq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_reset   = 1'b1;
        mac_tdata  = '0;
        mac_tkeep  = '0;
        mac_tlast  = 1'b0;
        mac_tuser  = 1'b0;
        mac_tvalid = 1'b0;
        rxd_tready = 1'b1;
        rxs_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset A tready", a_tready, 1'b0);
        check_eq("reset A rxd_tvalid", a_rxd_tvalid, 1'b0);
        check_eq("reset B rxs_tvalid", b_rxs_tvalid, 1'b0);
        check_eq("reset A dbg", a_dbg, 4'b0001);
        check_eq("reset B cnts", {b_bad, b_ovf}, 64'h0);
        @(posedge clk); #1;
        rx_reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post-reset tready", {a_tready, b_tready}, 2'b11);
        check_eq("post-reset dbg idle", a_dbg, 4'b0010);

        // Good 64B frame
        send_frame(64, 1'b0, 8'h01, -1);
        expect_frame("T1 A", 1'b0, 8'h01, 64);
        expect_frame("T1 B", 1'b1, 8'h01, 64);
        expect_sts("T1 A sts", 1'b0, 32'h0000_0040);
        expect_sts("T1 B sts", 1'b1, 32'h0000_0040);

        // 61B good frame then a tuser-bad frame
        send_frame(61, 1'b0, 8'h02, -1);
        send_frame(64, 1'b1, 8'h03, -1);
        expect_frame("T2 A", 1'b0, 8'h02, 61);
        expect_frame("T2 B", 1'b1, 8'h02, 61);
        expect_sts("T2 A sts", 1'b0, 32'h0100_003D);
        expect_sts("T2 B sts", 1'b1, 32'h0100_003D);
        expect_quiet("T2");
        check_eq("T2 bad cnts", {a_bad, b_bad}, {32'd1, 32'd1});

        // Data buffer overflow on the 16-deep instance with the consumer stalled
        rxd_tready = 1'b0;
        send_frame(80, 1'b0, 8'h04, -1);
        send_frame(80, 1'b0, 8'h05, -1);
        repeat (5) @(negedge clk);
        check_eq("T3 A stalled valid", a_rxd_tvalid, 1'b1);
        check_eq("T3 A stalled data", a_rxd_tdata, beat_data(8'h04, 0));
        repeat (3) @(negedge clk);
        check_eq("T3 A held data", a_rxd_tdata, beat_data(8'h04, 0));
        check_eq("T3 ovf cnts", {a_ovf, b_ovf}, {32'd1, 32'd0});
        @(posedge clk); #1;
        rxd_tready = 1'b1;
        expect_frame("T3 A", 1'b0, 8'h04, 80);
        expect_frame("T3 B f4", 1'b1, 8'h04, 80);
        expect_frame("T3 B f5", 1'b1, 8'h05, 80);
        expect_sts("T3 A sts", 1'b0, 32'h0200_0050);
        expect_sts("T3 B sts0", 1'b1, 32'h0200_0050);
        expect_sts("T3 B sts1", 1'b1, 32'h0300_0050);
        expect_quiet("T3");

        // Status queue overflow on the 2-deep instance
        rxs_tready = 1'b0;
        send_frame(16, 1'b0, 8'h06, -1);
        send_frame(16, 1'b0, 8'h07, -1);
        send_frame(16, 1'b0, 8'h08, -1);
        expect_frame("T4 A f6", 1'b0, 8'h06, 16);
        expect_frame("T4 A f7", 1'b0, 8'h07, 16);
        expect_frame("T4 B f6", 1'b1, 8'h06, 16);
        expect_frame("T4 B f7", 1'b1, 8'h07, 16);
        expect_frame("T4 B f8", 1'b1, 8'h08, 16);
        check_eq("T4 ovf cnts", {a_ovf, b_ovf}, {32'd2, 32'd0});
        @(posedge clk); #1;
        rxs_tready = 1'b1;
        expect_sts("T4 A sts0", 1'b0, 32'h0300_0010);
        expect_sts("T4 A sts1", 1'b0, 32'h0400_0010);
        expect_sts("T4 B sts0", 1'b1, 32'h0400_0010);
        expect_sts("T4 B sts1", 1'b1, 32'h0500_0010);
        expect_sts("T4 B sts2", 1'b1, 32'h0600_0010);
        expect_quiet("T4");

        // Oversize 9601B frame, then a normal frame
        send_frame(9601, 1'b0, 8'h09, -1);
        send_frame(64, 1'b0, 8'h0A, -1);
        expect_frame("T5 A", 1'b0, 8'h0A, 64);
        expect_frame("T5 B", 1'b1, 8'h0A, 64);
        expect_sts("T5 A sts", 1'b0, 32'h0500_0040);
        expect_sts("T5 B sts", 1'b1, 32'h0700_0040);
        check_eq("T5 B bad", b_bad, 32'd2);
        check_eq("T5 A ovf bad", {a_ovf, a_bad}, {32'd3, 32'd1});
        expect_quiet("T5");

        // Reset in the middle of a frame; the tail must be discarded
        send_frame(64, 1'b0, 8'h0B, 3);
        repeat (2) @(negedge clk);
        check_eq("T6 cnts cleared", {a_bad, a_ovf, b_bad, b_ovf}, 128'h0);
        check_eq("T6 dbg idle", {a_dbg, b_dbg}, 8'h22);
        send_frame(64, 1'b0, 8'h0C, -1);
        expect_frame("T6 A", 1'b0, 8'h0C, 64);
        expect_frame("T6 B", 1'b1, 8'h0C, 64);
        expect_sts("T6 A sts", 1'b0, 32'h0000_0040);
        expect_sts("T6 B sts", 1'b1, 32'h0000_0040);
        expect_quiet("T6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
